vc_arbiter: RTL and testbench

- Moves words from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) in the FIFO subsystem controlled by the FSM.
- Arbitrates VC0/VC1 with fixed VC0 priority plus an anti-starvation counter.
- Routes each word by its destination bit and respects D-FIFO almost-full backpressure.
- Runs only while the FSM reports active.

---
 rtl/vc_arbiter_pkg.sv | 17 +
 rtl/vc_arbiter_starve_counter.sv | 40 ++++
 rtl/vc_arbiter.sv | 147 ++++++++++++++
 tb/tb_vc_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vc_arbiter_pkg.sv
// vc_arbiter_pkg: shared encodings and default widths for the VC arbiter.
// Holds the arb_state encoding and the word/destination/counter defaults.
package vc_arbiter_pkg;

   localparam int DATA_W_DEF     = 6;
   localparam int DEST_BIT_DEF   = 4;
   localparam int MAX_CONSEC_DEF = 3;
   localparam int CNT_W_DEF      = 2;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_GNT0    = 2'b01,
      ARB_GNT1    = 2'b10,
      ARB_BLOCKED = 2'b11
   } arb_state_e;

endpackage

// File: rtl/vc_arbiter_starve_counter.sv
// vc_arbiter_starve_counter: saturating count of VC0 wins while VC1 waits.
// Ports: clk, reset (sync, high), inc_i, clr_i (clr wins), sat_o at MAX.
module vc_arbiter_starve_counter
   import vc_arbiter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int MAX   = MAX_CONSEC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !sat_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign sat_o = (cnt_q == MaxVal);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vc_arbiter.sv
// vc_arbiter: moves VC0/VC1 head words into D0/D1 with VC0 priority,
// anti-starvation for VC1, per-word routing and almost-full backpressure.
// Ports: enable gates grants; vcN_* FWFT heads; dK_almost_full backpressure;
// vcN_pop combinational; dK_push/dK_data, arb_state, arb_idle registered.
module vc_arbiter
   import vc_arbiter_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEST_BIT   = DEST_BIT_DEF,
   parameter int MAX_CONSEC = MAX_CONSEC_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              vc0_empty,
   input  logic              vc1_empty,
   input  logic [DATA_W-1:0] vc0_data,
   input  logic [DATA_W-1:0] vc1_data,
   input  logic              d0_almost_full,
   input  logic              d1_almost_full,
   output logic              vc0_pop,
   output logic              vc1_pop,
   output logic              d0_push,
   output logic              d1_push,
   output logic [DATA_W-1:0] d0_data,
   output logic [DATA_W-1:0] d1_data,
   output logic [1:0]        arb_state,
   output logic              arb_idle
);

   logic dest0;
   logic dest1;
   logic elig0;
   logic elig1;
   logic sat;
   logic gnt0;
   logic gnt1;
   logic any_gnt;

   logic              win_dest;
   logic [DATA_W-1:0] win_word;

   logic              push0_q, push0_d;
   logic              push1_q, push1_d;
   logic [DATA_W-1:0] data0_q, data0_d;
   logic [DATA_W-1:0] data1_q, data1_d;
   arb_state_e        state_q, state_d;
   logic              idle_q, idle_d;

   // A VC is eligible only if the FIFO its head word targets has room.
   assign dest0 = vc0_data[DEST_BIT];
   assign dest1 = vc1_data[DEST_BIT];

   assign elig0 = !vc0_empty &&
                  !(dest0 ? d1_almost_full : d0_almost_full);
   assign elig1 = !vc1_empty &&
                  !(dest1 ? d1_almost_full : d0_almost_full);

   // VC1 wins when VC0 cannot go or VC0 has used up its run.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (enable && !reset) begin
         if (elig1 && (!elig0 || sat)) begin
            gnt1 = 1'b1;
         end else if (elig0) begin
            gnt0 = 1'b1;
         end
      end
   end

   assign any_gnt = gnt0 | gnt1;
   assign vc0_pop = gnt0;
   assign vc1_pop = gnt1;

   assign win_word = gnt1 ? vc1_data : vc0_data;
   assign win_dest = gnt1 ? dest1 : dest0;

   vc_arbiter_starve_counter #(
      .CNT_W (CNT_W),
      .MAX   (MAX_CONSEC)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc_i (gnt0 && !vc1_empty),
      .clr_i (gnt1 || vc1_empty),
      .sat_o (sat)
   );

   always_comb begin
      push0_d = 1'b0;
      push1_d = 1'b0;
      data0_d = data0_q;
      data1_d = data1_q;
      if (any_gnt) begin
         if (win_dest) begin
            push1_d = 1'b1;
            data1_d = win_word;
         end else begin
            push0_d = 1'b1;
            data0_d = win_word;
         end
      end
   end

   always_comb begin
      state_d = ARB_IDLE;
      unique case (1'b1)
         gnt0:    state_d = ARB_GNT0;
         gnt1:    state_d = ARB_GNT1;
         default: begin
            if (enable && (!vc0_empty || !vc1_empty)) begin
               state_d = ARB_BLOCKED;
            end
         end
      endcase
   end

   assign idle_d = vc0_empty && vc1_empty && !any_gnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         push0_q <= 1'b0;
         push1_q <= 1'b0;
         data0_q <= '0;
         data1_q <= '0;
         state_q <= ARB_IDLE;
         idle_q  <= 1'b1;
      end else begin
         push0_q <= push0_d;
         push1_q <= push1_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         state_q <= state_d;
         idle_q  <= idle_d;
      end
   end

   assign d0_push   = push0_q;
   assign d1_push   = push1_q;
   assign d0_data   = data0_q;
   assign d1_data   = data1_q;
   assign arb_state = state_q;
   assign arb_idle  = idle_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: scoreboard bench for vc_arbiter.
// Expected pushes/state are queued per driven cycle and checked a cycle later.
module tb_vc_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       vc0_empty;
   logic       vc1_empty;
   logic [5:0] vc0_data;
   logic [5:0] vc1_data;
   logic       d0_almost_full;
   logic       d1_almost_full;
   logic       vc0_pop;
   logic       vc1_pop;
   logic       d0_push;
   logic       d1_push;
   logic [5:0] d0_data;
   logic [5:0] d1_data;
   logic [1:0] arb_state;
   logic       arb_idle;

   always #5 clk = ~clk;

   vc_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .vc0_empty      (vc0_empty),
      .vc1_empty      (vc1_empty),
      .vc0_data       (vc0_data),
      .vc1_data       (vc1_data),
      .d0_almost_full (d0_almost_full),
      .d1_almost_full (d1_almost_full),
      .vc0_pop        (vc0_pop),
      .vc1_pop        (vc1_pop),
      .d0_push        (d0_push),
      .d1_push        (d1_push),
      .d0_data        (d0_data),
      .d1_data        (d1_data),
      .arb_state      (arb_state),
      .arb_idle       (arb_idle)
   );

   typedef struct {
      logic       p0;
      logic       p1;
      logic [5:0] d0;
      logic [5:0] d1;
      logic [1:0] st;
      logic       idle;
   } exp_t;

   exp_t  sb[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    m_cnt       = 0;
   logic [5:0] m_d0   = '0;
   logic [5:0] m_d1   = '0;
   string phase       = "init";
   int    g;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s/%s got=%0h exp=%0h t=%0t",
                  phase, tag, got, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check pops, queue expectation,
   // then check registered outputs just after the posedge.
   task automatic cyc(input logic rst, input logic en,
                      input logic v0e, input logic v1e,
                      input logic [5:0] v0d, input logic [5:0] v1d,
                      input logic a0, input logic a1,
                      output int gnt);
      exp_t e, o;
      logic e0, e1;
      logic [5:0] w;
      @(negedge clk);
      reset          = rst;
      enable         = en;
      vc0_empty      = v0e;
      vc1_empty      = v1e;
      vc0_data       = v0d;
      vc1_data       = v1d;
      d0_almost_full = a0;
      d1_almost_full = a1;
      #1;
      e0 = !v0e && !(v0d[4] ? a1 : a0);
      e1 = !v1e && !(v1d[4] ? a1 : a0);
      gnt = 0;
      if (!rst && en) begin
         if (e1 && (!e0 || m_cnt == 3)) gnt = 2;
         else if (e0)                   gnt = 1;
      end
      chk("vc0_pop", 32'(vc0_pop), 32'(gnt == 1));
      chk("vc1_pop", 32'(vc1_pop), 32'(gnt == 2));
      e.p0 = 1'b0;
      e.p1 = 1'b0;
      if (gnt != 0) begin
         w = (gnt == 1) ? v0d : v1d;
         if (w[4]) begin
            e.p1 = 1'b1;
            m_d1 = w;
         end else begin
            e.p0 = 1'b1;
            m_d0 = w;
         end
      end
      if (gnt == 1)      e.st = 2'b01;
      else if (gnt == 2) e.st = 2'b10;
      else if (en && (!v0e || !v1e)) e.st = 2'b11;
      else               e.st = 2'b00;
      e.idle = v0e && v1e && (gnt == 0);
      if (rst) begin
         m_d0   = '0;
         m_d1   = '0;
         e.st   = 2'b00;
         e.idle = 1'b1;
         m_cnt  = 0;
      end else if (gnt == 2 || v1e) begin
         m_cnt = 0;
      end else if (gnt == 1) begin
         if (m_cnt < 3) m_cnt++;
      end
      e.d0 = m_d0;
      e.d1 = m_d1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk("d0_push",   32'(d0_push),   32'(o.p0));
      chk("d1_push",   32'(d1_push),   32'(o.p1));
      chk("d0_data",   32'(d0_data),   32'(o.d0));
      chk("d1_data",   32'(d1_data),   32'(o.d1));
      chk("arb_state", 32'(arb_state), 32'(o.st));
      chk("arb_idle",  32'(arb_idle),  32'(o.idle));
   endtask

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      vc0_empty      = 1'b1;
      vc1_empty      = 1'b1;
      vc0_data       = '0;
      vc1_data       = '0;
      d0_almost_full = 1'b0;
      d1_almost_full = 1'b0;

      phase = "reset";
      cyc(1, 1, 0, 1, 6'b000001, 6'b0, 0, 0, g);
      cyc(1, 1, 0, 1, 6'b000001, 6'b0, 0, 0, g);
      chk("rst_state", 32'(arb_state), 32'd0);
      chk("rst_idle",  32'(arb_idle),  32'd1);

      phase = "single";
      cyc(0, 1, 0, 1, 6'b010011, 6'b0, 0, 0, g);
      chk("sr_d1push", 32'(d1_push),   32'd1);
      chk("sr_d1data", 32'(d1_data),   32'h13);
      chk("sr_d0push", 32'(d0_push),   32'd0);
      chk("sr_state",  32'(arb_state), 32'd1);
      cyc(0, 1, 1, 1, 6'b0, 6'b0, 0, 0, g);

      phase = "starve";
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 0, 6'b000101, 6'b001010, 0, 0, g);
         chk("st_word", 32'(d0_data),
             (i % 4 == 3) ? 32'h0a : 32'h05);
      end

      phase = "bp";
      cyc(0, 1, 0, 0, 6'b000111, 6'b010110, 1, 0, g);
      chk("bp_state", 32'(arb_state), 32'd2);
      chk("bp_d1",    32'(d1_data),   32'h16);
      cyc(0, 1, 0, 1, 6'b000111, 6'b010110, 1, 0, g);
      chk("bp_blk",   32'(arb_state), 32'd3);

      phase = "samefull";
      cyc(0, 1, 0, 0, 6'b000111, 6'b001001, 1, 0, g);
      chk("sf_state", 32'(arb_state), 32'd3);

      phase = "sat";
      for (int i = 0; i < 3; i++)
         cyc(0, 1, 0, 0, 6'b000001, 6'b010010, 0, 0, g);
      cyc(0, 1, 0, 0, 6'b000001, 6'b010010, 0, 1, g);
      chk("sat_vc0", 32'(d0_push), 32'd1);
      cyc(0, 1, 0, 0, 6'b000001, 6'b010010, 0, 0, g);
      chk("sat_vc1", 32'(d1_push), 32'd1);

      phase = "endrop";
      cyc(0, 1, 0, 1, 6'b000011, 6'b0, 0, 0, g);
      cyc(0, 0, 0, 1, 6'b000011, 6'b0, 0, 0, g);
      chk("en_pushlast", 32'(d0_push), 32'd0);
      cyc(0, 0, 0, 1, 6'b000011, 6'b0, 0, 0, g);

      phase = "midrst";
      cyc(0, 1, 0, 0, 6'b000100, 6'b001000, 0, 0, g);
      cyc(0, 1, 0, 0, 6'b000100, 6'b001000, 0, 0, g);
      cyc(1, 1, 0, 0, 6'b000100, 6'b001000, 0, 0, g);
      chk("mr_d0push", 32'(d0_push), 32'd0);
      chk("mr_d1push", 32'(d1_push), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 0, 6'b000100, 6'b001000, 0, 0, g);
         chk("mr_word", 32'(d0_data),
             (i == 3) ? 32'h08 : 32'h04);
      end

      phase = "random";
      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 49) == 0),
             ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0),
             6'($urandom), 6'($urandom),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), g);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
